// File: rtl/obi_data_responder.sv
// OBI data-bus target: word RAM behind a bounded in-order response queue,
// with LFSR-driven grant/response stalls and an error address window.
module obi_data_responder #(
  parameter int          MEM_ADDR_WIDTH  = 12,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter logic [31:0] ERR_BASE        = 32'h1A11_F000,
  parameter logic [31:0] ERR_SIZE        = 32'h100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        gnt_stall_en_i,
  input  logic        rvalid_stall_en_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [2:0]  outstanding_o
);

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  localparam logic [2:0] MAX_O = 3'(MAX_OUTSTANDING);

  logic [31:0] mem [2**MEM_ADDR_WIDTH];
  resp_t       q [MAX_OUTSTANDING];

  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic [2:0]  outstanding;
  logic [2:0]  qcnt;
  logic [2:0]  slot;
  logic        gstall;
  logic        rstall_nxt;
  logic        xfer;
  logic        err;
  logic        pop;
  logic        bypass;
  logic        deq;
  logic        push;
  logic [MEM_ADDR_WIDTH-1:0] widx;
  resp_t       new_e;
  resp_t       head;

  assign lfsr_nxt = {lfsr[14:0],
                     lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign gstall = gnt_stall_en_i & (lfsr[1:0] == 2'b00);
  // rvalid_o is registered, so judge the stall on the LFSR value
  // that will be current in the cycle the response shows up.
  assign rstall_nxt = rvalid_stall_en_i & (lfsr_nxt[3:2] == 2'b00);

  assign gnt_o = req_i & ~gstall & (outstanding < MAX_O);
  assign xfer  = req_i & gnt_o;
  assign widx  = addr_i[MEM_ADDR_WIDTH+1:2];

  assign err = (ERR_SIZE != 32'd0)
             & ({1'b0, addr_i} >= {1'b0, ERR_BASE})
             & ({1'b0, addr_i} < ({1'b0, ERR_BASE} + {1'b0, ERR_SIZE}));

  assign new_e.rdata = (we_i | err) ? 32'd0 : mem[widx];
  assign new_e.err   = err;

  assign head   = (qcnt != 3'd0) ? q[0] : new_e;
  assign pop    = ((qcnt != 3'd0) | xfer) & ~rstall_nxt;
  assign bypass = pop & (qcnt == 3'd0);
  assign deq    = pop & ~bypass;
  assign push   = xfer & ~bypass;
  assign slot   = qcnt - {2'b00, deq};

  assign outstanding_o = outstanding;

  always_ff @(posedge clk_i) begin
    if (!rst_i && xfer && we_i && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[widx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (deq) begin
      for (int i = 0; i < MAX_OUTSTANDING - 1; i++) begin
        q[i] <= q[i+1];
      end
    end
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (push && slot == 3'(i)) q[i] <= new_e;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr        <= LFSR_SEED;
      outstanding <= 3'd0;
      qcnt        <= 3'd0;
      rvalid_o    <= 1'b0;
      rdata_o     <= 32'd0;
      err_o       <= 1'b0;
    end else begin
      lfsr        <= lfsr_nxt;
      outstanding <= outstanding + {2'b00, xfer} - {2'b00, rvalid_o};
      qcnt        <= qcnt + {2'b00, push} - {2'b00, deq};
      rvalid_o    <= pop;
      if (pop) begin
        rdata_o <= head.rdata;
        err_o   <= head.err;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (outstanding <= MAX_O);
      assert (!(rvalid_o && outstanding == 3'd0));
      assert (outstanding == qcnt + {2'b00, rvalid_o});
    end
  end

endmodule

// File: tb/tb_obi_data_responder.sv
// Directed and randomised checks of obi_data_responder against a
// transaction-level model (RAM map plus expected-response queue).
module tb_obi_data_responder;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        gse = 1'b0;
  logic        rse = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [2:0]  outstanding;

  always #5 clk = ~clk;

  obi_data_responder dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .gnt_stall_en_i    (gse),
    .rvalid_stall_en_i (rse),
    .req_i             (req),
    .gnt_o             (gnt),
    .addr_i            (addr),
    .we_i              (we),
    .be_i              (be),
    .wdata_i           (wdata),
    .rvalid_o          (rvalid),
    .rdata_o           (rdata),
    .err_o             (err),
    .outstanding_o     (outstanding)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          known;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] ram_m[int];
  logic [32:0] got[$];
  int          got_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          granted = 0;
  int          responded = 0;
  int          last_gnt = 0;
  bit          saw_full = 0;
  exp_t        e;
  int          k;
  logic [31:0] t;

  function automatic void chk(bit ok, string nm,
                              logic [31:0] act, logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic bit in_err(logic [31:0] a);
    return (a >= 32'h1A11_F000) && (a < 32'h1A11_F100);
  endfunction

  function automatic int word_of(logic [31:0] a);
    return int'((a >> 2) % 32'd4096);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst_i) begin
      expq.delete();
      granted   = 0;
      responded = 0;
    end else begin
      chk(!(gnt && !req), "gnt_without_req", 32'(gnt), 32'(req));
      chk(int'(outstanding) == granted - responded, "outstanding",
          32'(outstanding), 32'(granted - responded));
      chk(!(gnt && outstanding >= 3'd2), "gnt_when_full",
          32'(outstanding), 32'd2);
      if (req && !gnt && outstanding == 3'd2) saw_full = 1;
      if (rvalid) begin
        got.push_back({err, rdata});
        got_cyc.push_back(cyc);
        responded++;
        chk(expq.size() != 0, "unexpected_rvalid", rdata, 32'd0);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          if (e.known) chk(rdata == e.rdata, "rdata", rdata, e.rdata);
          chk(err == e.err, "err", 32'(err), 32'(e.err));
        end
      end
      if (req && gnt) begin
        granted++;
        last_gnt = cyc;
        e.err   = in_err(addr);
        e.rdata = 32'd0;
        e.known = 1;
        if (!e.err) begin
          k = word_of(addr);
          if (!we) begin
            e.known = ram_m.exists(k);
            if (e.known) e.rdata = ram_m[k];
          end else if (be == 4'hF) begin
            ram_m[k] = wdata;
          end else if (ram_m.exists(k)) begin
            t = ram_m[k];
            for (int b = 0; b < 4; b++)
              if (be[b]) t[8*b +: 8] = wdata[8*b +: 8];
            ram_m[k] = t;
          end
        end
        expq.push_back(e);
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       output int waited);
    got.delete();
    got_cyc.delete();
    @(posedge clk);
    #1;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    waited = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (gnt) begin
        waited = i;
        break;
      end
    end
    chk(waited >= 0, "grant_timeout", 32'(waited), 32'd0);
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output logic ee,
                           output int lat);
    d = 32'd0; ee = 1'b0; lat = -1;
    for (int i = 0; i < 100; i++) begin
      if (got.size() > 0) break;
      @(negedge clk);
      #1;
    end
    if (got.size() > 0) begin
      {ee, d} = got.pop_front();
      lat = got_cyc.pop_front() - last_gnt;
    end
    chk(lat >= 0, "resp_timeout", 32'(lat), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          w;
    int          lat;
    bit          gw;
    bit          found;
    logic [31:0] d;
    logic        ee;
    logic [31:0] pre [3];
    logic [31:0] a;

    pre[0] = 32'hA0A0_A0A0;
    pre[1] = 32'hA4A4_A4A4;
    pre[2] = 32'hA8A8_A8A8;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(rvalid == 1'b0, "reset_rvalid", 32'(rvalid), 32'd0);
    chk(outstanding == 3'd0, "reset_outstanding", 32'(outstanding), 32'd0);
    chk(rdata == 32'd0, "reset_rdata", rdata, 32'd0);
    chk(err == 1'b0, "reset_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    issue(1'b1, 32'h40, 4'hF, 32'hDEAD_BEEF, w);
    chk(w == 0, "t1_wr_gnt_wait", 32'(w), 32'd0);
    wait_resp(d, ee, lat);
    chk(lat == 1, "t1_wr_latency", 32'(lat), 32'd1);
    chk(d == 32'd0, "t1_wr_rdata", d, 32'd0);
    issue(1'b0, 32'h40, 4'h0, 32'h0, w);
    chk(w == 0, "t1_rd_gnt_wait", 32'(w), 32'd0);
    wait_resp(d, ee, lat);
    chk(lat == 1, "t1_rd_latency", 32'(lat), 32'd1);
    chk(d == 32'hDEAD_BEEF, "t1_rd_data", d, 32'hDEAD_BEEF);
    chk(ee == 1'b0, "t1_rd_err", 32'(ee), 32'd0);

    issue(1'b1, 32'h80, 4'hF, 32'h1122_3344, w);
    wait_resp(d, ee, lat);
    issue(1'b1, 32'h80, 4'b0010, 32'h0000_AA00, w);
    wait_resp(d, ee, lat);
    issue(1'b0, 32'h80, 4'h0, 32'h0, w);
    wait_resp(d, ee, lat);
    chk(d == 32'h1122_AA44, "t2_be_merge", d, 32'h1122_AA44);

    for (int j = 0; j < 3; j++) begin
      issue(1'b1, 32'(4 * j), 4'hF, pre[j], w);
      wait_resp(d, ee, lat);
    end
    rse = 1'b1;
    saw_full = 0;
    for (int r = 0; r < 10; r++) begin
      got.delete();
      got_cyc.delete();
      @(posedge clk);
      #1;
      for (int j = 0; j < 3; j++) begin
        req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'(4 * j);
        gw = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          #1;
          if (gnt) begin
            gw = 1;
            break;
          end
        end
        chk(gw, "t3_grant_timeout", 32'(gw), 32'd1);
        @(posedge clk);
        #1;
      end
      req = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (got.size() >= 3) break;
        @(negedge clk);
        #1;
      end
      chk(got.size() == 3, "t3_resp_count", 32'(got.size()), 32'd3);
      for (int j = 0; j < 3 && j < got.size(); j++)
        chk(got[j][31:0] == pre[j], "t3_order_data", got[j][31:0], pre[j]);
    end
    chk(saw_full, "t3_gnt_dropped_when_full", 32'(saw_full), 32'd1);
    rse = 1'b0;

    issue(1'b1, 32'h3010, 4'hF, 32'h1234_5678, w);
    wait_resp(d, ee, lat);
    issue(1'b1, 32'h1A11_F010, 4'hF, 32'h5555_5555, w);
    wait_resp(d, ee, lat);
    chk(ee == 1'b1, "t4_err", 32'(ee), 32'd1);
    chk(d == 32'd0, "t4_err_rdata", d, 32'd0);
    issue(1'b0, 32'h3010, 4'h0, 32'h0, w);
    wait_resp(d, ee, lat);
    chk(d == 32'h1234_5678, "t4_alias_kept", d, 32'h1234_5678);
    chk(ee == 1'b0, "t4_alias_err", 32'(ee), 32'd0);
    issue(1'b0, 32'h1A11_F100, 4'h0, 32'h0, w);
    wait_resp(d, ee, lat);
    chk(ee == 1'b0, "t4_window_end", 32'(ee), 32'd0);
    issue(1'b0, 32'h1A11_F0FC, 4'h0, 32'h0, w);
    wait_resp(d, ee, lat);
    chk(ee == 1'b1, "t4_window_last", 32'(ee), 32'd1);

    for (int i = 0; i < 64; i++) begin
      issue(1'b1, 32'(4 * i), 4'hF, $urandom, w);
      wait_resp(d, ee, lat);
    end
    gse = 1'b1;
    rse = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 9) == 0)
        a = 32'h1A11_F000 + 32'(4 * $urandom_range(0, 70));
      else
        a = 32'(4 * $urandom_range(0, 63));
      req = 1'b1; addr = a; we = 1'($urandom_range(0, 1));
      be = 4'($urandom); wdata = $urandom;
      gw = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        #1;
        if (gnt) begin
          gw = 1;
          break;
        end
      end
      chk(gw, "t5_grant_timeout", 32'(gw), 32'd1);
      @(posedge clk);
      #1;
      req = 1'b0;
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 300; i++) begin
      if (granted == responded && expq.size() == 0) break;
      @(negedge clk);
      #1;
    end
    chk(granted == responded, "t5_drain", 32'(responded), 32'(granted));
    gse = 1'b0;
    rse = 1'b0;

    rse = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h3010;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (outstanding == 3'd2) begin
        found = 1;
        break;
      end
    end
    chk(found, "t6_reach_two", 32'(outstanding), 32'd2);
    @(posedge clk);
    #1;
    req = 1'b0;
    rst_i = 1'b1;
    rse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk(rvalid == 1'b0, "t6_no_rvalid", 32'(rvalid), 32'd0);
      chk(outstanding == 3'd0, "t6_outstanding", 32'(outstanding), 32'd0);
    end
    issue(1'b0, 32'h3010, 4'h0, 32'h0, w);
    chk(w == 0, "t6_gnt_wait", 32'(w), 32'd0);
    wait_resp(d, ee, lat);
    chk(lat == 1, "t6_latency", 32'(lat), 32'd1);
    chk(d == 32'h1234_5678, "t6_rdata", d, 32'h1234_5678);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
